painterengine_gpu_scanout_ctrl: RTL and testbench

Frame scanout controller that sits between the framebuffer memory port and the GPU DVI timing generator. On a start pulse it fetches clip_width*clip_height 32-bit pixels from memory using credit-limited burst reads. It buffers the pixels in an internal show-ahead FIFO and hands one pixel to the DVI per next-pixel strobe. It reports busy, done and underflow status to the register block.

---
 rtl/painterengine_gpu_scanout_pkg.sv | 21 ++
 rtl/painterengine_gpu_scanout_fifo.sv | 53 +++++
 rtl/painterengine_gpu_scanout_ctrl.sv | 170 +++++++++++++++++
 tb/tb_painterengine_gpu_scanout_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_scanout_pkg.sv
// Shared types and constants for the framebuffer scanout controller.
// The optional underflow counter is enabled by PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN (see top).
package painterengine_gpu_scanout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int unsigned BYTES_PER_PIXEL = 4;

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((32'd1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/painterengine_gpu_scanout_fifo.sv
// Synchronous show-ahead pixel FIFO: the head word is visible on o_data while not empty, 0 otherwise.
// Part of the scanout controller (optional macro PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN has no effect here).
module painterengine_gpu_scanout_fifo
    import painterengine_gpu_scanout_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 32
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_push,
    input  logic [WIDTH-1:0]                  i_data,
    input  logic                              i_pop,
    output logic [WIDTH-1:0]                  o_data,
    output logic [fifo_clog2(DEPTH):0]        o_count,
    output logic                              o_empty,
    output logic                              o_full
);
    localparam int unsigned CW   = fifo_clog2(DEPTH);
    localparam int unsigned CNTW = CW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNTW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNTW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNTW'(1);
        end
    end

endmodule

// File: rtl/painterengine_gpu_scanout_ctrl.sv
// Frame scanout controller: credit-limited burst reads into a show-ahead FIFO drained by the DVI.
// Define PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN to add the saturating o_wire_underflow_count output.
//
// state | meaning
// IDLE  | waiting for start; pops and read beats ignored
// ISSUE | issuing bursts while words remain and credit allows
// DRAIN | all bursts issued; waiting for the last beat and the last pop
// DONE  | one cycle; done/busy update registered on leaving
module painterengine_gpu_scanout_ctrl
    import painterengine_gpu_scanout_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_reset,
    input  logic                  i_wire_start,
    input  logic [ADDR_WIDTH-1:0] i_wire_base_addr,
    input  logic [15:0]           i_wire_clip_width,
    input  logic [15:0]           i_wire_clip_height,
    output logic                  o_wire_busy,
    output logic                  o_wire_done,
    output logic                  o_wire_rd_req_valid,
    input  logic                  i_wire_rd_req_ready,
    output logic [ADDR_WIDTH-1:0] o_wire_rd_req_addr,
    output logic [7:0]            o_wire_rd_req_len,
    input  logic                  i_wire_rd_data_valid,
    input  logic [31:0]           i_wire_rd_data,
    input  logic                  i_wire_next_rgb,
    output logic [31:0]           o_wire_rgba,
    output logic                  o_wire_rgba_valid,
    output logic                  o_wire_underflow
`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]           o_wire_underflow_count
`endif
);
    localparam int unsigned CNTW = fifo_clog2(FIFO_DEPTH) + 1;

    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [31:0]           r_issue_rem;
    logic [31:0]           r_recv_rem;
    logic [31:0]           r_pop_rem;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [7:0]            r_req_len;
    logic                  r_req_valid;
    logic [CNTW-1:0]       r_inflight;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_underflow;

    logic [31:0]           w_total;
    logic [7:0]            w_len;
    logic                  w_start_ok;
    logic                  w_hs;
    logic                  w_beat;
    logic                  w_pop_req;
    logic                  w_fifo_pop;
    logic                  w_underflow_pop;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic [CNTW-1:0]       w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [31:0]           w_fifo_data;

    assign w_total         = 32'(i_wire_clip_width) * 32'(i_wire_clip_height);
    assign w_start_ok      = i_wire_start && (r_state == IDLE);
    assign w_hs            = r_req_valid && i_wire_rd_req_ready;
    assign w_beat          = i_wire_rd_data_valid && (r_state != IDLE) && (r_inflight != '0);
    assign w_pop_req       = i_wire_next_rgb && (r_state != IDLE);
    assign w_fifo_pop      = w_pop_req && !w_fifo_empty;
    assign w_underflow_pop = w_pop_req && w_fifo_empty;
    assign w_len           = (r_issue_rem < 32'(BURST_LEN)) ? r_issue_rem[7:0] : 8'(BURST_LEN);
    // Reserving FIFO space for every outstanding word means a returning beat never meets a full FIFO.
    assign w_credit_ok     = (32'(w_fifo_count) + 32'(r_inflight) + 32'(w_len)) <= 32'(FIFO_DEPTH);
    assign w_issue         = (r_state == ISSUE) && !r_req_valid && (r_issue_rem != '0) && w_credit_ok;

    painterengine_gpu_scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clock (i_wire_clock),
        .i_reset (i_wire_reset),
        .i_push  (w_beat && !w_fifo_full),
        .i_data  (i_wire_rd_data),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_wire_start) w_state_next = (w_total == '0) ? DONE : ISSUE;
            ISSUE:   if ((r_issue_rem == '0) && !r_req_valid) w_state_next = DRAIN;
            DRAIN:   if ((r_recv_rem == '0) && (r_pop_rem == '0)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            r_state     <= IDLE;
            r_issue_rem <= '0;
            r_recv_rem  <= '0;
            r_pop_rem   <= '0;
            r_req_addr  <= '0;
            r_req_len   <= '0;
            r_req_valid <= 1'b0;
            r_inflight  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == DONE);
            if (w_start_ok) begin
                r_busy      <= 1'b1;
                r_issue_rem <= w_total;
                r_recv_rem  <= w_total;
                r_pop_rem   <= w_total;
                r_req_addr  <= i_wire_base_addr;
                r_underflow <= 1'b0;
            end else begin
                if (r_state == DONE) r_busy <= 1'b0;
                if (w_issue) begin
                    r_req_valid <= 1'b1;
                    r_req_len   <= w_len;
                end
                if (w_hs) begin
                    r_req_valid <= 1'b0;
                    r_req_addr  <= r_req_addr + ADDR_WIDTH'(r_req_len) * ADDR_WIDTH'(BYTES_PER_PIXEL);
                    r_issue_rem <= r_issue_rem - 32'(r_req_len);
                end
                r_inflight <= r_inflight + (w_hs ? CNTW'(r_req_len) : '0) - (w_beat ? CNTW'(1) : '0);
                if (w_beat)          r_recv_rem  <= r_recv_rem - 32'd1;
                if (w_fifo_pop)      r_pop_rem   <= r_pop_rem - 32'd1;
                if (w_underflow_pop) r_underflow <= 1'b1;
            end
        end
    end

`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] r_underflow_count;

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset || w_start_ok) r_underflow_count <= '0;
        else if (w_underflow_pop && (r_underflow_count != 16'hFFFF))
            r_underflow_count <= r_underflow_count + 16'd1;
    end

    assign o_wire_underflow_count = r_underflow_count;
`endif

    assign o_wire_busy         = r_busy;
    assign o_wire_done         = r_done;
    assign o_wire_rd_req_valid = r_req_valid;
    assign o_wire_rd_req_addr  = r_req_addr;
    assign o_wire_rd_req_len   = r_req_len;
    assign o_wire_rgba         = w_fifo_data;
    assign o_wire_rgba_valid   = !w_fifo_empty;
    assign o_wire_underflow    = r_underflow;

endmodule

// File: tb/tb_painterengine_gpu_scanout_ctrl.sv
// Scoreboard bench for the scanout controller: expected requests/pixels queued by stimulus, checked by a monitor.
// Also covers o_wire_underflow_count when PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN is defined.
module tb_painterengine_gpu_scanout_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BLEN  = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst, start, ready, rd_valid, next_rgb;
    logic [31:0] base, rd_data;
    logic [15:0] w, h;
    logic        busy, done, req_valid, rgba_valid, underflow;
    logic [31:0] req_addr, rgba;
    logic [7:0]  req_len;
`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] ucnt;
`endif

    int    tests = 0;
    int    fails = 0;
    req_t  exp_req[$];
    logic [31:0] exp_pix[$];
    logic [31:0] beat_q[$];
    req_t  mon_req;
    logic [31:0] mon_pix;
    bit    mem_en = 1'b0;
    bit    pop_auto = 1'b0;
    int    force_req = 0, force_done = 0;
    int    inject_req = 0, inject_done = 0;
    int    flush_req = 0, flush_done = 0;
    int    req_seen = 0;
    int    seen0;
    bit    got;

    painterengine_gpu_scanout_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BLEN),
        .ADDR_WIDTH (32)
    ) dut (
        .i_wire_clock         (clk),
        .i_wire_reset         (rst),
        .i_wire_start         (start),
        .i_wire_base_addr     (base),
        .i_wire_clip_width    (w),
        .i_wire_clip_height   (h),
        .o_wire_busy          (busy),
        .o_wire_done          (done),
        .o_wire_rd_req_valid  (req_valid),
        .i_wire_rd_req_ready  (ready),
        .o_wire_rd_req_addr   (req_addr),
        .o_wire_rd_req_len    (req_len),
        .i_wire_rd_data_valid (rd_valid),
        .i_wire_rd_data       (rd_data),
        .i_wire_next_rgb      (next_rgb),
        .o_wire_rgba          (rgba),
        .o_wire_rgba_valid    (rgba_valid),
        .o_wire_underflow     (underflow)
`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
        ,
        .o_wire_underflow_count (ucnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [7:0] l);
        exp_req.push_back({a, l});
    endtask

    task automatic push_pix(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_pix.push_back(pix(a + 32'(4 * i)));
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [15:0] ww, input logic [15:0] hh);
        @(posedge clk); #1;
        start = 1'b1; base = b; w = ww; h = hh;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({name, "_reached"}, 32'(got), 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Memory model: records each accepted burst and returns its words in order while mem_en.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && req_valid && ready)
                for (int k = 0; k < int'(req_len); k++) beat_q.push_back(pix(req_addr + 32'(4 * k)));
            @(posedge clk); #1;
            if (flush_req != flush_done) begin
                beat_q.delete();
                flush_done = flush_req;
            end
            if (inject_req != inject_done) begin
                rd_valid = 1'b1;
                rd_data  = 32'hDEAD_BEEF;
                inject_done++;
            end else if (mem_en && beat_q.size() != 0) begin
                rd_valid = 1'b1;
                rd_data  = beat_q.pop_front();
            end else begin
                rd_valid = 1'b0;
                rd_data  = '0;
            end
        end
    end

    initial begin
        next_rgb = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_req != force_done) begin
                next_rgb = 1'b1;
                force_done++;
            end else begin
                next_rgb = pop_auto && rgba_valid;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && ready) begin
                req_seen++;
                if (exp_req.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: got addr 0x%08h len %0d, required no request", req_addr, req_len);
                end else begin
                    mon_req = exp_req.pop_front();
                    check("req_addr", req_addr, mon_req.addr);
                    check("req_len", 32'(req_len), 32'(mon_req.len));
                end
            end
            if (next_rgb && rgba_valid) begin
                if (exp_pix.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pixel: got 0x%08h, required no pixel", rgba);
                end else begin
                    mon_pix = exp_pix.pop_front();
                    check("pixel", rgba, mon_pix);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; w = '0; h = '0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_rgba_valid", 32'(rgba_valid), 32'd0);
        check("rst_rgba", rgba, 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // Small frame: 4x2 in a single burst.
        push_req(32'h1000, 8'd8);
        push_pix(32'h1000, 8);
        mem_en = 1'b1; pop_auto = 1'b1;
        start_frame(32'h1000, 16'd4, 16'd2);
        wait_done("small", 200);
        check("small_underflow", 32'(underflow), 32'd0);
        check("small_req_left", 32'(exp_req.size()), 32'd0);
        check("small_pix_left", 32'(exp_pix.size()), 32'd0);

        // Multi-burst 40x1, request held against ready low first.
        ready = 1'b0;
        push_req(32'h1000, 8'd16);
        push_req(32'h1040, 8'd16);
        push_req(32'h1080, 8'd8);
        push_pix(32'h1000, 40);
        start_frame(32'h1000, 16'd40, 16'd1);
        repeat (4) @(negedge clk);
        check("hold_valid", 32'(req_valid), 32'd1);
        check("hold_addr", req_addr, 32'h1000);
        check("hold_len", 32'(req_len), 32'd16);
        check("hold_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        wait_done("multi", 400);
        check("multi_req_left", 32'(exp_req.size()), 32'd0);
        check("multi_pix_left", 32'(exp_pix.size()), 32'd0);

        // Credit stall: 32x1 into a 16-deep FIFO with no pops.
        pop_auto = 1'b0;
        push_req(32'h2000, 8'd16);
        push_req(32'h2040, 8'd16);
        push_pix(32'h2000, 32);
        seen0 = req_seen;
        start_frame(32'h2000, 16'd32, 16'd1);
        repeat (40) @(negedge clk);
        check("stall_req_count", 32'(req_seen - seen0), 32'd1);
        check("stall_req_valid", 32'(req_valid), 32'd0);
        check("stall_rgba_valid", 32'(rgba_valid), 32'd1);
        check("stall_head", rgba, 32'hC0DE_2000);
        pop_auto = 1'b1;
        wait_done("stall", 300);
        check("stall_req_left", 32'(exp_req.size()), 32'd0);
        check("stall_pix_left", 32'(exp_pix.size()), 32'd0);

        // Underflow: pop before any data arrives.
        mem_en = 1'b0; pop_auto = 1'b0;
        push_req(32'h3000, 8'd4);
        push_pix(32'h3000, 4);
        start_frame(32'h3000, 16'd4, 16'd1);
        @(negedge clk);
        force_req++;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_rgba", rgba, 32'd0);
        check("uf_rgba_valid", 32'(rgba_valid), 32'd0);
`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
        check("uf_count", 32'(ucnt), 32'd1);
`endif
        mem_en = 1'b1; pop_auto = 1'b1;
        wait_done("uf", 200);
        check("uf_sticky", 32'(underflow), 32'd1);
        check("uf_fifo_empty_at_done", 32'(rgba_valid), 32'd0);
        check("uf_pix_left", 32'(exp_pix.size()), 32'd0);

        // Zero-size frame: done two cycles after start, no request; start clears underflow.
        start_frame(32'h4000, 16'd0, 16'd5);
        @(negedge clk);
        check("zero_done_early", 32'(done), 32'd0);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_uf_cleared", 32'(underflow), 32'd0);
`ifdef PAINTERENGINE_SCANOUT_UNDERFLOW_CNT_EN
        check("zero_count_cleared", 32'(ucnt), 32'd0);
`endif
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero_done_pulse", 32'(done), 32'd0);

        // Start while busy is ignored.
        mem_en = 1'b0; pop_auto = 1'b0;
        push_req(32'h5000, 8'd4);
        push_pix(32'h5000, 4);
        start_frame(32'h5000, 16'd4, 16'd1);
        repeat (4) @(negedge clk);
        start_frame(32'h6000, 16'd8, 16'd8);
        @(negedge clk);
        check("busy_start_busy", 32'(busy), 32'd1);
        mem_en = 1'b1; pop_auto = 1'b1;
        wait_done("busy_start", 200);
        check("busy_start_req_left", 32'(exp_req.size()), 32'd0);
        check("busy_start_pix_left", 32'(exp_pix.size()), 32'd0);
        check("busy_start_fifo_empty", 32'(rgba_valid), 32'd0);

        // Reset mid-frame after the first burst has landed in the FIFO.
        mem_en = 1'b1; pop_auto = 1'b0;
        push_req(32'h7000, 8'd16);
        start_frame(32'h7000, 16'd32, 16'd1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rgba_valid) got = 1'b1;
        end
        check("mid_fill", 32'(got), 32'd1);
        mem_en = 1'b0;
        flush_req++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_req_valid", 32'(req_valid), 32'd0);
        check("mid_rgba_valid", 32'(rgba_valid), 32'd0);
        check("mid_rgba", rgba, 32'd0);
        inject_req++;
        repeat (3) @(negedge clk);
        check("mid_beat_dropped", 32'(rgba_valid), 32'd0);
        check("mid_req_left", 32'(exp_req.size()), 32'd0);
        mem_en = 1'b1; pop_auto = 1'b1;
        push_req(32'h8000, 8'd8);
        push_pix(32'h8000, 8);
        start_frame(32'h8000, 16'd4, 16'd2);
        wait_done("after_rst", 200);
        check("after_rst_underflow", 32'(underflow), 32'd0);
        check("after_rst_req_left", 32'(exp_req.size()), 32'd0);
        check("after_rst_pix_left", 32'(exp_pix.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
